sklansky_subtractor_pipe: RTL and testbench

- Pipelined WIDTH-bit prefix subtractor. Computes DIFF = A - B as A + ~B + 1.
- Uses a Sklansky parallel-prefix borrow network with one register stage per prefix level.
- Valid/ready handshakes on both sides.
- Companion to the combinational Sklansky adder: the datapath's subtract/compare unit, placed where a result every cycle with backpressure is needed.

---
 rtl/sklansky_subtractor_pipe.sv | 131 +++++++++++++
 tb/tb_sklansky_subtractor_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sklansky_subtractor_pipe.sv
// Pipelined WIDTH-bit subtractor (A + ~B + 1) built on a Sklansky prefix network,
// one register per prefix level, with a single global valid/ready enable.
module sklansky_subtractor_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] DIFF,
    output logic             BO,
    output logic             OVF,
    output logic             ZERO
);
    localparam int LEVELS = $clog2(WIDTH);

    // Index k holds the register after stage k (0 = operand terms, LEVELS = last level).
    logic [LEVELS:0]              vld_q, vld_d;
    logic [LEVELS:0]              amsb_q, amsb_d;
    logic [LEVELS:0]              bmsb_q, bmsb_d;
    logic [LEVELS:0][WIDTH-1:0]   p_q, p_d;
    logic [LEVELS:0][WIDTH-1:0]   g_q, g_d;
    // T is not needed after the last level.
    logic [LEVELS-1:0][WIDTH-1:0] t_q, t_d;

    logic             ovld_q, ovld_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bo_q, bo_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             en;
    logic [WIDTH-1:0] nb;

    always_comb begin
        en     = ~ovld_q | OUT_READY;
        nb     = ~B;
        vld_d  = vld_q;
        amsb_d = amsb_q;
        bmsb_d = bmsb_q;
        p_d    = p_q;
        g_d    = g_q;
        t_d    = t_q;
        ovld_d = ovld_q;
        diff_d = diff_q;
        bo_d   = bo_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (en) begin
            vld_d[0] = IN_VALID;
            if (IN_VALID) begin
                p_d[0]    = A ^ nb;
                t_d[0]    = A | nb;
                g_d[0]    = A & nb;
                // Carry-in of 1 folded into bit 0.
                g_d[0][0] = (A[0] & nb[0]) | (A[0] | nb[0]);
                amsb_d[0] = A[WIDTH-1];
                bmsb_d[0] = B[WIDTH-1];
            end
            for (int k = 1; k <= LEVELS; k++) begin
                vld_d[k]  = vld_q[k-1];
                amsb_d[k] = amsb_q[k-1];
                bmsb_d[k] = bmsb_q[k-1];
                p_d[k]    = p_q[k-1];
                g_d[k]    = g_q[k-1];
                if (k < LEVELS) begin
                    t_d[k] = t_q[k-1];
                end
                for (int i = 0; i < WIDTH; i++) begin
                    if (((i >> (k - 1)) & 1) == 1) begin
                        // Partner is the top bit of the lower half of this 2^k block.
                        g_d[k][i] = g_q[k-1][i]
                                    | (t_q[k-1][i] & g_q[k-1][((i >> k) << k) + (1 << (k - 1)) - 1]);
                        if (k < LEVELS) begin
                            t_d[k][i] = t_q[k-1][i]
                                        & t_q[k-1][((i >> k) << k) + (1 << (k - 1)) - 1];
                        end
                    end
                end
            end
            ovld_d    = vld_q[LEVELS];
            diff_d[0] = ~p_q[LEVELS][0];
            for (int i = 1; i < WIDTH; i++) begin
                diff_d[i] = p_q[LEVELS][i] ^ g_q[LEVELS][i-1];
            end
            bo_d   = ~g_q[LEVELS][WIDTH-1];
            ovf_d  = (amsb_q[LEVELS] != bmsb_q[LEVELS]) && (diff_d[WIDTH-1] != amsb_q[LEVELS]);
            zero_d = (diff_d == '0);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q  <= '0;
            amsb_q <= '0;
            bmsb_q <= '0;
            p_q    <= '0;
            g_q    <= '0;
            t_q    <= '0;
            ovld_q <= 1'b0;
            diff_q <= '0;
            bo_q   <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
            p_q    <= p_d;
            g_q    <= g_d;
            t_q    <= t_d;
            ovld_q <= ovld_d;
            diff_q <= diff_d;
            bo_q   <= bo_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign IN_READY  = en;
    assign OUT_VALID = ovld_q;
    assign DIFF      = diff_q;
    assign BO        = bo_q;
    assign OVF       = ovf_q;
    assign ZERO      = zero_q;

endmodule

// File: tb/tb_sklansky_subtractor_pipe.sv
// Bench for sklansky_subtractor_pipe: directed vectors, reset flush, backpressure and
// randomized traffic against an arithmetic reference model with an in-order scoreboard.
module tb_sklansky_subtractor_pipe;
    localparam int W = 16;
    localparam int S = $clog2(W) + 2;

    typedef struct packed {
        logic         bo;
        logic         ovf;
        logic         zero;
        logic [W-1:0] diff;
    } res_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] DIFF;
    logic         BO;
    logic         OVF;
    logic         ZERO;

    int   n_checks = 0;
    int   n_pass   = 0;
    res_t exp_q[$];

    always #5 CLK = ~CLK;

    sklansky_subtractor_pipe #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .A         (A),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .DIFF      (DIFF),
        .BO        (BO),
        .OVF       (OVF),
        .ZERO      (ZERO)
    );

    // Reference: plain unsigned/signed integer arithmetic.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t r;
        int   sd;
        r.diff = a - b;
        r.bo   = (a < b);
        sd     = int'($signed(a)) - int'($signed(b));
        r.ovf  = (sd >= (1 << (W - 1))) || (sd < -(1 << (W - 1)));
        r.zero = (r.diff == '0);
        return r;
    endfunction

    function automatic res_t observed();
        res_t r;
        r.bo   = BO;
        r.ovf  = OVF;
        r.zero = ZERO;
        r.diff = DIFF;
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        int seen;
        RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0; A = '0; B = '0;
        repeat (2) tick();
        RST = 1'b0;
        #1;
        n_checks++;
        if (OUT_VALID !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID);
        else n_pass++;
        n_checks++;
        if (observed() !== res_t'(0)) $display("FAIL reset_outputs: got %h expected 0", observed());
        else n_pass++;
        n_checks++;
        if (IN_READY !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", IN_READY);
        else n_pass++;
        // Three operations in flight, then reset: none may emerge.
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        repeat (3) begin
            A = W'($urandom); B = W'($urandom);
            tick();
        end
        IN_VALID = 1'b0;
        RST      = 1'b1;
        tick();
        RST  = 1'b0;
        seen = 0;
        repeat (3 * S) begin
            #1;
            if (OUT_VALID === 1'b1) seen++;
            tick();
        end
        n_checks++;
        if (seen != 0) $display("FAIL reset_flush: got %0d outputs expected 0", seen);
        else n_pass++;
    endtask

    task automatic test_vector(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] ediff, input logic ebo, input logic eovf,
                               input logic ezero);
        int   early;
        res_t e;
        e.diff = ediff; e.bo = ebo; e.ovf = eovf; e.zero = ezero;
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        A = a; B = b;
        #1;
        n_checks++;
        if (IN_READY !== 1'b1) $display("FAIL %s_in_ready: got %b expected 1", name, IN_READY);
        else n_pass++;
        tick();
        IN_VALID = 1'b0;
        early    = 0;
        for (int k = 1; k < S; k++) begin
            #1;
            if (OUT_VALID !== 1'b0) early++;
            tick();
        end
        #1;
        n_checks++;
        if (early != 0 || OUT_VALID !== 1'b1)
            $display("FAIL %s_latency: got early=%0d valid=%b expected early=0 valid=1",
                     name, early, OUT_VALID);
        else n_pass++;
        n_checks++;
        if (observed() !== e) $display("FAIL %s_result: got %h expected %h", name, observed(), e);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a_arr[10];
        logic [W-1:0] b_arr[10];
        int   sent, got, cyc, stalls;
        logic prev_stall;
        res_t prev, obs, e;
        for (int i = 0; i < 10; i++) begin
            a_arr[i] = W'($urandom);
            b_arr[i] = W'($urandom);
        end
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; stalls = 0; prev_stall = 1'b0; prev = '0;
        while (got < 10 && cyc < 200) begin
            OUT_READY = !(cyc >= 8 && cyc < 12);
            IN_VALID  = (sent < 10);
            if (sent < 10) begin
                A = a_arr[sent]; B = b_arr[sent];
            end
            #1;
            obs = observed();
            if (prev_stall) begin
                n_checks++;
                if (OUT_VALID !== 1'b1 || obs !== prev)
                    $display("FAIL b2b_hold: got valid=%b %h expected valid=1 %h", OUT_VALID, obs, prev);
                else n_pass++;
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b0) begin
                stalls++;
                n_checks++;
                if (IN_READY !== 1'b0) $display("FAIL b2b_in_ready: got %b expected 0", IN_READY);
                else n_pass++;
            end
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL b2b_extra: got %h expected none", obs);
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) $display("FAIL b2b_result %0d: got %h expected %h", got, obs, e);
                    else n_pass++;
                end
                got++;
            end
            if (IN_VALID === 1'b1 && IN_READY === 1'b1) begin
                exp_q.push_back(model(A, B));
                sent++;
            end
            prev_stall = (OUT_VALID === 1'b1) && (OUT_READY === 1'b0);
            prev       = obs;
            tick();
            cyc++;
        end
        IN_VALID = 1'b0;
        n_checks++;
        if (got != 10 || stalls != 4)
            $display("FAIL b2b_count: got %0d results %0d stalls expected 10 results 4 stalls",
                     got, stalls);
        else n_pass++;
    endtask

    task automatic test_random();
        int           accepted, emitted, cyc, bad;
        logic [W-1:0] cur_a, cur_b;
        res_t         obs, e;
        exp_q.delete();
        accepted = 0; emitted = 0; cyc = 0; bad = 0;
        cur_a = W'($urandom); cur_b = W'($urandom);
        while ((accepted < 10000 || exp_q.size() != 0) && cyc < 60000) begin
            IN_VALID  = (accepted < 10000) && ($urandom_range(0, 3) != 0);
            OUT_READY = (accepted >= 10000) || ($urandom_range(0, 3) != 0);
            A = IN_VALID ? cur_a : W'($urandom);
            B = IN_VALID ? cur_b : W'($urandom);
            #1;
            obs = observed();
            n_checks++;
            if (IN_READY !== (!OUT_VALID || OUT_READY))
                $display("FAIL rand_in_ready cyc %0d: got %b expected %b", cyc, IN_READY,
                         (!OUT_VALID || OUT_READY));
            else n_pass++;
            if (OUT_VALID === 1'b1 && OUT_READY === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) $display("FAIL rand_extra: got %h expected none", obs);
                else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        if (bad < 10)
                            $display("FAIL rand_result %0d: got %h expected %h", emitted, obs, e);
                        bad++;
                    end else n_pass++;
                end
                emitted++;
            end
            if (IN_VALID === 1'b1 && IN_READY === 1'b1) begin
                exp_q.push_back(model(A, B));
                accepted++;
                cur_a = W'($urandom); cur_b = W'($urandom);
            end
            tick();
            cyc++;
        end
        IN_VALID = 1'b0;
        n_checks++;
        if (accepted != 10000 || emitted != accepted)
            $display("FAIL rand_count: got %0d outputs for %0d accepted expected 10000 each",
                     emitted, accepted);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_vector("basic",   16'h1234, 16'h0034, 16'h1200, 1'b0, 1'b0, 1'b0);
        test_vector("wrap",    16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        test_vector("zero",    16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b1);
        test_vector("ovf_neg", 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        test_vector("ovf_pos", 16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0);
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
